// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: funct codes, FSM state encoding and decode helpers for the ALU sequencer
package alu_seq_pkg;

    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SINGLE   = 3'd1,
        ST_MUL_LOAD = 3'd2,
        ST_MUL_RUN  = 3'd3,
        ST_HILO_WR  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    function automatic logic is_alu_op(input logic [5:0] f);
        return f inside {FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT};
    endfunction

    function automatic logic is_hilo_read(input logic [5:0] f);
        return f inside {FN_MFHI, FN_MFLO};
    endfunction

    // Codes that finish in one working cycle: ALU, shifter, or a HI/LO read through the MUX
    function automatic logic is_single_op(input logic [5:0] f);
        return is_alu_op(f) || f == FN_SLL || is_hilo_read(f);
    endfunction

endpackage

// File: rtl/mul_step_counter.sv
// mul_step_counter: counts multiplier shift-add steps and flags the final one
module mul_step_counter
    import alu_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MUL_CYCLES - 1);

    logic [CNT_W-1:0] count_d, count_q;

    assign last  = count_q == LAST_VAL;
    assign count = count_q;

    // Saturate at the final step so the count never wraps while stepping
    always_comb begin
        count_d = clear ? '0 : (inc && !last) ? count_q + CNT_W'(1) : count_q;
    end

    // Step count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer driving ALU, shifter, MULTU multiplier, HI/LO and output MUX
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [5:0] in_funct,
    output logic       in_ready,
    input  logic       flush,
    output logic       alu_en,
    output logic       shift_en,
    output logic       mul_load,
    output logic       mul_step,
    output logic       hilo_we,
    output logic [5:0] mux_signal,
    output logic       done,
    output logic       illegal,
    output logic       busy
);

    state_e           state_d, state_q;
    logic [5:0]       op_d, op_q;
    logic             illegal_d, illegal_q;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_last;
    logic [CNT_W-1:0] step_cnt;

    assign in_ready  = state_q == ST_IDLE && !flush;
    assign accept    = in_valid && in_ready;
    assign cnt_clear = state_q != ST_MUL_RUN || flush;

    mul_step_counter #(
        .MUL_CYCLES(MUL_CYCLES),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .inc  (mul_step),
        .count(step_cnt),
        .last (cnt_last)
    );

    // Next state and request capture; flush overrides every transition
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = in_funct;
                    illegal_d = !(is_single_op(in_funct) || in_funct == FN_MULTU);
                    state_d   = is_single_op(in_funct) ? ST_SINGLE :
                                in_funct == FN_MULTU   ? ST_MUL_LOAD : ST_DONE;
                end
            end
            ST_SINGLE:   state_d = ST_DONE;
            ST_MUL_LOAD: state_d = ST_MUL_RUN;
            ST_MUL_RUN:  state_d = cnt_last ? ST_HILO_WR : ST_MUL_RUN;
            ST_HILO_WR:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Moore strobes decoded from the current state only
    always_comb begin
        alu_en     = state_q == ST_SINGLE && is_alu_op(op_q);
        shift_en   = state_q == ST_SINGLE && op_q == FN_SLL;
        mul_load   = state_q == ST_MUL_LOAD;
        mul_step   = state_q == ST_MUL_RUN;
        hilo_we    = state_q == ST_HILO_WR;
        done       = state_q == ST_DONE;
        illegal    = state_q == ST_DONE && illegal_q;
        busy       = state_q != ST_IDLE;
        mux_signal = state_q == ST_IDLE ? 6'b000000 : op_q;
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // The step counter must never pass the final step
    assert property (@(posedge clk) disable iff (!reset) step_cnt <= CNT_W'(MUL_CYCLES - 1));

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed scoreboard bench for the ALU sequencer
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] in_funct = 6'd0;
    logic       in_ready, alu_en, shift_en, mul_load, mul_step, hilo_we, done, illegal, busy;
    logic [5:0] mux_signal;

    int         n_vec = 0;
    int         n_err = 0;
    int         hilo_cnt = 0;
    logic [6:0] sb[$];

    alu_seq_ctrl #(.MUL_CYCLES(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_funct  (in_funct),
        .in_ready  (in_ready),
        .flush     (flush),
        .alu_en    (alu_en),
        .shift_en  (shift_en),
        .mul_load  (mul_load),
        .mul_step  (mul_step),
        .hilo_we   (hilo_we),
        .mux_signal(mux_signal),
        .done      (done),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input bit expect_done, input bit ill);
        if (expect_done) sb.push_back({f, ill});
        in_valid = 1'b1;
        in_funct = f;
        tick();
        in_valid = 1'b0;
    endtask

    // Scoreboard: every done pops the oldest expected result; also watch strobe exclusivity
    always @(negedge clk) begin
        logic [6:0] e;
        if (hilo_we) hilo_cnt++;
        if (alu_en | shift_en | mul_load | mul_step | hilo_we)
            chk("strobe_onehot", 32'($countones({alu_en, shift_en, mul_load, mul_step, hilo_we})), 1);
        if (done) begin
            chk("done_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("done_mux", 32'(mux_signal), 32'(e[6:1]));
                chk("done_illegal", 32'(illegal), 32'(e[0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mux", 32'(mux_signal), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b1;
        tick();

        // ADD, with in_funct changed after accept
        issue(6'b100000, 1, 0);
        chk("add_alu_en", 32'(alu_en), 1);
        chk("add_in_ready", 32'(in_ready), 0);
        in_funct = 6'b111111;
        tick();
        chk("add_done", 32'(done), 1);
        chk("add_mux", 32'(mux_signal), 32'(6'b100000));
        chk("add_alu_off", 32'(alu_en), 0);
        tick();
        chk("add_ready_after", 32'(in_ready), 1);
        chk("add_idle", 32'(busy), 0);

        // MULTU full run
        issue(6'b011001, 1, 0);
        chk("mul_load", 32'(mul_load), 1);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk($sformatf("mul_step_%0d", i), 32'(mul_step), 1);
        end
        tick();
        chk("mul_hilo_we", 32'(hilo_we), 1);
        chk("mul_step_end", 32'(mul_step), 0);
        tick();
        chk("mul_done", 32'(done), 1);
        tick();

        // MFLO after MULTU
        issue(6'b010010, 1, 0);
        chk("mflo_no_alu", 32'({alu_en, shift_en}), 0);
        tick();
        chk("mflo_done", 32'(done), 1);
        chk("mflo_mux", 32'(mux_signal), 32'(6'b010010));
        tick();

        // Illegal code
        issue(6'b111111, 1, 1);
        chk("ill_done", 32'(done), 1);
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_mux", 32'(mux_signal), 32'(6'b111111));
        tick();
        chk("ill_idle", 32'(busy), 0);

        // Flush at MUL_RUN step 5, then SLL
        issue(6'b011001, 0, 0);
        repeat (5) tick();
        chk("fl_in_run", 32'(mul_step), 1);
        flush = 1'b1;
        tick();
        chk("fl_busy", 32'(busy), 0);
        chk("fl_count", 32'(dut.u_cnt.count), 0);
        chk("fl_ready_blocked", 32'(in_ready), 0);
        flush = 1'b0;
        #1;
        chk("fl_ready", 32'(in_ready), 1);
        repeat (3) tick();
        chk("fl_still_idle", 32'(busy), 0);
        issue(6'b000000, 1, 0);
        chk("sll_shift_en", 32'(shift_en), 1);
        tick();
        chk("sll_done", 32'(done), 1);
        tick();

        // Flush together with in_valid in IDLE: no accept, then accepted a cycle later
        flush = 1'b1;
        in_valid = 1'b1;
        in_funct = 6'b100100;
        tick();
        chk("flv_no_accept", 32'(busy), 0);
        flush = 1'b0;
        issue(6'b100100, 1, 0);
        chk("flv_accepted", 32'(busy), 1);
        chk("flv_alu_en", 32'(alu_en), 1);
        tick();
        chk("flv_done", 32'(done), 1);
        tick();

        // Reset asserted at MUL_RUN cycle 10
        issue(6'b011001, 0, 0);
        repeat (10) tick();
        chk("rm_in_run", 32'(mul_step), 1);
        reset = 1'b0;
        #1;
        chk("rm_busy", 32'(busy), 0);
        chk("rm_in_ready", 32'(in_ready), 1);
        chk("rm_mux", 32'(mux_signal), 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (30) tick();
        chk("rm_idle", 32'(busy), 0);

        chk("hilo_pulses", 32'(hilo_cnt), 1);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer for the ALU datapath: ALU core, shifter, 32-step MULTU multiplier, HI/LO registers, output MUX.
- Accepts one 6-bit funct code per request over a valid/ready handshake.
- Drives per-cycle unit enables, multiplier load/step, and the HI/LO write.
- Holds the MUX select (`mux_signal`) stable while `done` is asserted.

Parameters:
- MUL_CYCLES, 32, number of multiplier step cycles for MULTU (legal range 1..63).
- CNT_W, 6, width of the step counter; must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  request present.
- in_funct  input  6  funct code; sampled on accept.
- in_ready  output  1  controller can accept a request.
- flush  input  1  synchronous abort of any operation in progress.
- alu_en  output  1  ALU core computes this cycle (AND/OR/ADD/SUB/SLT).
- shift_en  output  1  shifter computes this cycle (SLL).
- mul_load  output  1  multiplier loads operands and clears its product.
- mul_step  output  1  multiplier performs one shift-add step.
- hilo_we  output  1  HI/LO registers capture the product.
- mux_signal  output  6  select code to the output MUX.
- done  output  1  result valid on the MUX output this cycle.
- illegal  output  1  qualifies `done`: funct code unsupported.
- busy  output  1  state is not IDLE.

Behaviour:

Reset values (all outputs, while `reset`=0):
- `in_ready`=1; all other outputs 0; `mux_signal`=6'b000000.
- Counter=0; state=IDLE.
- Reset asserted mid-operation: immediate return to IDLE; no `done` and no `hilo_we` are produced.

Supported codes:
- AND=100100, OR=100101, ADD=100000, SUB=100010, SLT=101010.
- SLL=000000, MULTU=011001, MFHI=010000, MFLO=010010.

Handshake:
- Accept occurs on a rising edge where `in_valid`=1 and `in_ready`=1.
- `in_ready`=1 only in IDLE, and only when `flush`=0.
- `in_funct` is latched into `op_q` at accept.
- `mux_signal` = `op_q` in every non-IDLE state; 0 in IDLE.

States:
- IDLE
  - On accept: SINGLE if the code is ALU, SLL, MFHI or MFLO; MUL_LOAD if MULTU; DONE with `illegal_q`=1 otherwise.
- SINGLE (1 cycle)
  - `alu_en`=1 for ALU codes; `shift_en`=1 for SLL; neither for MFHI/MFLO.
  - Next state: DONE.
- MUL_LOAD (1 cycle)
  - `mul_load`=1; counter cleared to 0.
  - Next state: MUL_RUN.
- MUL_RUN (MUL_CYCLES cycles)
  - `mul_step`=1; counter increments each cycle.
  - When counter == MUL_CYCLES-1, next state is HILO_WR.
- HILO_WR (1 cycle)
  - `hilo_we`=1.
  - Next state: DONE.
- DONE (1 cycle)
  - `done`=1; `illegal`=`illegal_q`.
  - Next state: IDLE.
  - `in_ready` is low in DONE, so there is no back-to-back accept; the earliest next accept is the edge after DONE.

Latency (accept edge to the cycle `done`=1):
- Single-cycle codes: 2 cycles.
- Illegal codes: 1 cycle.
- MULTU: MUL_CYCLES+3 cycles (35 at default).

Flush:
- `flush`=1 on any edge forces the next state to IDLE; counter is cleared.
- No `done` is produced for the aborted operation.
- Flush sampled in HILO_WR: `hilo_we` is still 1 for that cycle, because outputs decode from the current state.
- Flush and `in_valid` together in IDLE: flush wins and no accept occurs.

Other rules:
- All strobes are Moore outputs decoded from the state register; at most one of `alu_en`, `shift_en`, `mul_load`, `mul_step`, `hilo_we` is high per cycle.
- Counter stops at MUL_CYCLES-1 and never wraps inside MUL_RUN.
- `in_funct` changes after accept have no effect.
- MFHI/MFLO cannot overlap a MULTU in progress (`in_ready`=0), so they read committed HI/LO values.

Decomposition:
- Package `alu_seq_pkg`:
  - funct code constants (AND, OR, ADD, SUB, SLT, SLL, MULTU, MFHI, MFLO);
  - state encoding localparams (IDLE, SINGLE, MUL_LOAD, MUL_RUN, HILO_WR, DONE; 3-bit binary);
  - an `is_alu_op` decode function.
- Sub-module `mul_step_counter`:
  - inputs: clk, reset, clear, inc;
  - outputs: count, last (last = count == MUL_CYCLES-1);
  - parameterised by MUL_CYCLES and CNT_W.

Test Plan:
- Reset mid-MULTU: assert `reset`=0 at cycle 10 of MUL_RUN → same cycle: `busy`=0, `in_ready`=1, `mux_signal`=0; no `hilo_we` ever pulses.
- ADD: accept `in_funct`=100000 at edge T → `alu_en`=1 at T+1; `done`=1, `illegal`=0, `mux_signal`=100000 at T+2; `in_ready`=1 at T+3.
- MULTU (MUL_CYCLES=32): accept 011001 at T → `mul_load` at T+1; `mul_step` high for exactly 32 cycles (T+2..T+33); `hilo_we` at T+34; `done` at T+35. Then MFLO (010010) → `done` with `mux_signal`=010010 two cycles after its accept.
- Illegal code 111111 accepted at T → `done`=1, `illegal`=1, `mux_signal`=111111 at T+1; no unit strobes at any point.
- Flush at MUL_RUN step 5 → IDLE next cycle, counter=0, no `done`. A following SLL (000000) completes normally with `shift_en` then `done`.
- Flush together with `in_valid` (funct 100100) in IDLE → no accept (`busy` stays 0). Request held one more cycle with `flush`=0 → accepted; `done` two cycles later.
